// File: rtl/demux_sel_sequencer.sv
// Feeds (data, sel) items from a small FIFO to a 1-to-8 demux, each held HOLD_CYCLES cycles.
// Latency: an item pushed into an idle block shows on the outputs one edge later; push is refused when full.
module demux_sel_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int SEL_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic             d_out,
  output logic [SEL_W-1:0] s_out,
  output logic             out_active,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t           state;
  logic [CW-1:0]    hold_cnt;
  logic             held_data;

  logic [SEL_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_data;
  logic [SEL_W-1:0] head_sel;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && ((state == IDLE) || ((state == DRIVE) && (hold_cnt == '0)));
  assign {head_sel, head_data} = mem[rd_ptr];
  assign busy     = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sel, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pop overrides the DRIVE-expiry branch: the next item either follows
  // seamlessly (same sel) or goes through one GUARD cycle with D low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      held_data  <= 1'b0;
      d_out      <= 1'b0;
      s_out      <= '0;
      out_active <= 1'b0;
    end else begin
      case (state)
        GUARD: begin
          state      <= DRIVE;
          d_out      <= held_data;
          out_active <= 1'b1;
          hold_cnt   <= CW'(HOLD_CYCLES - 1);
        end
        DRIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            state      <= IDLE;
            d_out      <= 1'b0;
            out_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        held_data <= head_data;
        if (head_sel != s_out) begin
          state      <= GUARD;
          s_out      <= head_sel;
          d_out      <= 1'b0;
          out_active <= 1'b0;
        end else begin
          state      <= DRIVE;
          d_out      <= head_data;
          out_active <= 1'b1;
          hold_cnt   <= CW'(HOLD_CYCLES - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench for demux_sel_sequencer (DEPTH=4, HOLD_CYCLES=2): per-cycle vector table
// plus a hand-written back-pressure sequence and a continuous break-before-make monitor.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_data;
  logic [2:0] in_sel;
  logic       d_out;
  logic [2:0] s_out;
  logic       out_active;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_sel_sequencer #(
    .DEPTH(4),
    .HOLD_CYCLES(2),
    .SEL_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_sel(in_sel),
    .d_out(d_out),
    .s_out(s_out),
    .out_active(out_active),
    .busy(busy)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic       dat;
    logic [2:0] sel;
    logic       e_d;
    logic [2:0] e_s;
    logic       e_act;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int r, input int v, input int d, input int s,
                     input int ed, input int es, input int ea, input int eb, input int er);
    vec_t t;
    t.rst    = (r != 0);
    t.vld    = (v != 0);
    t.dat    = (d != 0);
    t.sel    = 3'(s);
    t.e_d    = (ed != 0);
    t.e_s    = 3'(es);
    t.e_act  = (ea != 0);
    t.e_busy = (eb != 0);
    t.e_rdy  = (er != 0);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst_n    = vecs[i].rst;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].dat;
      in_sel   = vecs[i].sel;
      @(posedge clk);
      #1;
      check("d_out",      i, 8'(d_out),      8'(vecs[i].e_d));
      check("s_out",      i, 8'(s_out),      8'(vecs[i].e_s));
      check("out_active", i, 8'(out_active), 8'(vecs[i].e_act));
      check("busy",       i, 8'(busy),       8'(vecs[i].e_busy));
      check("in_ready",   i, 8'(in_ready),   8'(vecs[i].e_rdy));
    end
  endtask

  // d_out must be low in the first cycle after any select change.
  logic       mon_en = 1'b0;
  logic [2:0] prev_s;
  always @(negedge clk) begin
    if (mon_en && (s_out !== prev_s)) begin
      checks++;
      if (d_out !== 1'b0) begin
        failures++;
        $display("FAIL bbm: s_out %0d->%0d with d_out=%b required 0", prev_s, s_out, d_out);
      end
    end
    prev_s <= s_out;
  end

  int         end_reset;
  int         end_t4;
  int         idx;
  bit         rec_on;
  bit         saw_full;
  bit         acc;
  bit         done;
  logic [4:0] trace[$];
  logic [4:0] exp_e;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 1'b1;
    in_sel   = 3'd3;

    // reset with in_valid high: nothing accepted
    for (int i = 0; i < 3; i++) add(0,1,1,3, 0,0,0,0,0);
    end_reset = vecs.size();
    // single item sel=5 data=1: guard, two drive cycles, idle
    add(1,1,1,5, 0,0,0,1,1);
    add(1,0,0,0, 0,5,0,1,1);
    add(1,0,0,0, 1,5,1,1,1);
    add(1,0,0,0, 1,5,1,1,1);
    add(1,0,0,0, 0,5,0,0,1);
    // reset, then three sel=0 items back to back: no guard, 1,1,0,0,1,1
    add(0,0,0,0, 0,0,0,0,0);
    add(1,1,1,0, 0,0,0,1,1);
    add(1,1,0,0, 1,0,1,1,1);
    add(1,1,1,0, 1,0,1,1,1);
    add(1,0,0,0, 0,0,1,1,1);
    add(1,0,0,0, 0,0,1,1,1);
    add(1,0,0,0, 1,0,1,1,1);
    add(1,0,0,0, 1,0,1,1,1);
    add(1,0,0,0, 0,0,0,0,1);
    // sel=2 then sel=6: guard, drive x2, guard, drive x2, idle
    add(1,1,1,2, 0,0,0,1,1);
    add(1,1,1,6, 0,2,0,1,1);
    add(1,0,0,0, 1,2,1,1,1);
    add(1,0,0,0, 1,2,1,1,1);
    add(1,0,0,0, 0,6,0,1,1);
    add(1,0,0,0, 1,6,1,1,1);
    add(1,0,0,0, 1,6,1,1,1);
    add(1,0,0,0, 0,6,0,0,1);
    end_t4 = vecs.size();
    // reset in the second drive cycle of item 1; queued items are dropped
    add(1,1,1,3, 0,7,0,1,1);
    add(1,1,1,4, 0,3,0,1,1);
    add(1,1,1,5, 1,3,1,1,1);
    add(1,0,0,0, 1,3,1,1,1);
    add(0,0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 6; i++) add(1,0,0,0, 0,0,0,0,1);

    run_rows(0, end_reset);
    mon_en = 1'b1;
    run_rows(end_reset, end_t4);

    // back-pressure: 8 items sel 0..7, each held until accepted
    idx = 0; rec_on = 0; saw_full = 0; done = 0;
    for (int c = 0; c < 200; c++) begin
      if (idx < 8) begin
        in_valid = 1'b1;
        in_sel   = idx[2:0];
        in_data  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_full = 1;
      @(posedge clk);
      #1;
      if (rec_on && idx == 8 && !busy) begin
        done = 1;
        break;
      end
      if (rec_on) trace.push_back({out_active, s_out, d_out});
      if (acc) begin
        idx++;
        rec_on = 1;
      end
    end
    in_valid = 1'b0;
    check("bp_done",     0, 8'(done),         8'd1);
    check("bp_accepted", 0, 8'(idx),          8'd8);
    check("bp_saw_full", 0, 8'(saw_full),     8'd1);
    check("bp_len",      0, 8'(trace.size()), 8'd24);
    for (int k = 0; k < trace.size() && k < 24; k++) begin
      if (k % 3 == 0) exp_e = {1'b0, 3'(k / 3), 1'b0};
      else            exp_e = {1'b1, 3'(k / 3), 1'b1};
      check("bp_trace", k, 8'(trace[k]), 8'(exp_e));
    end

    run_rows(end_t4, vecs.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
- Upstream feeder for the 1-to-8 demultiplexer: drives its data input (D) and 3-bit select (S).
- Accepts (data, channel) items over a valid/ready interface and buffers them in a small FIFO.
- Presents each item to the demux for a fixed number of cycles.
- Inserts a break-before-make guard cycle, with D forced low, whenever the select value changes, so no unintended demux output ever pulses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- HOLD_CYCLES, 2, cycles each item is driven with its data value; at least 1.
- SEL_W, 3, select width; 3 for the 1x8 demux.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  item offered.
- in_ready  output  1  FIFO can accept; equals !full; 0 while rst_n is low.
- in_data  input  1  data bit to route.
- in_sel  input  SEL_W  destination channel.
- d_out  output  1  to demux D; registered.
- s_out  output  SEL_W  to demux S; registered.
- out_active  output  1  high exactly in DRIVE cycles; registered.
- busy  output  1  FIFO non-empty or state != IDLE.

Behaviour:
- Reset (rst_n low at an edge): FIFO emptied, state IDLE, d_out=0, s_out=0, out_active=0. Reset wins over all other activity, including mid-DRIVE and mid-GUARD. Queued items are discarded.
- Accept: push on an edge with in_valid && in_ready. No bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both happen, and the count is unchanged.
- Ordering: strict FIFO. No item is lost or duplicated.
- FSM states: IDLE, GUARD, DRIVE. A pop happens only on the transitions marked "pop" below.
- IDLE: d_out=0, out_active=0, s_out holds its last value.
  - If the FIFO is non-empty, pop the head. If head sel != s_out, go to GUARD; otherwise go to DRIVE.
- GUARD (exactly 1 cycle): s_out=new sel, d_out=0, out_active=0. Then go to DRIVE.
- DRIVE: s_out=sel, d_out=item data, out_active=1. The hold counter starts at HOLD_CYCLES-1 and decrements each cycle.
  - At counter 0, if the FIFO is non-empty: pop the head. Go to DRIVE directly if head sel == current s_out (no gap); otherwise go to GUARD.
  - At counter 0, if the FIFO is empty: go to IDLE.
- Invariant: s_out changes only on an edge where the next d_out is 0. d_out is never high in the first cycle after s_out changes.
- Latency: an item accepted at edge E0, with the FSM in IDLE, appears on the outputs (GUARD or DRIVE) from edge E1.
  - An item with data=0 still occupies HOLD_CYCLES DRIVE cycles (out_active=1, d_out=0).
- FIFO pointers are log2(DEPTH) bits and wrap. The count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Throughput:
  - 1 item per HOLD_CYCLES cycles for repeated sel.
  - 1 item per HOLD_CYCLES+1 cycles for alternating sel.

Test Plan (DEPTH=4, HOLD_CYCLES=2):
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, d_out=0, s_out=0, out_active=0, busy=0; no item is accepted.
2. Single item sel=5, data=1 pushed at E0 after reset:
   - E1: GUARD (s_out=5, d_out=0).
   - E2-E3: DRIVE (d_out=1, out_active=1).
   - E4: IDLE, d_out=0, s_out=5, busy=0.
3. Three items sel=0, data=1,0,1 pushed back-to-back after reset -> no GUARD. Six consecutive DRIVE cycles from E1, d_out pattern 1,1,0,0,1,1, s_out=0 throughout.
4. Items sel=2 then sel=6, both data=1 -> DRIVE sel 2 for 2 cycles, one GUARD cycle (s_out=6, d_out=0), DRIVE sel 6 for 2 cycles. Checker confirms d_out=0 on every cycle in which s_out differs from the previous cycle.
5. Back-pressure: offer 8 items with sel=0..7 (data=1) on consecutive cycles, holding each until accepted.
   - in_ready deasserts while the FIFO is full.
   - All 8 items emerge in order, each preceded by a GUARD; total output time 24 cycles; no loss or duplication.
6. Reset mid-operation: queue 3 items, assert rst_n=0 during the second DRIVE cycle of item 1 -> next edge d_out=0, s_out=0, out_active=0, busy=0. After release, the queued items are never output.
